// File: rtl/uart_rx_core.sv
// uart_rx_core: LSB-first 8N1 UART receiver with mid-bit sampling, framing/overrun flags and a pop FIFO.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check driving parity_err.
module uart_rx_core #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_BREAK  = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_sync1;
  logic             r_rxd_s;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_overrun;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bit;
  logic             r_parity_err;
`endif

  logic w_bit_end;
  logic w_push_req;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_overrun;

  assign w_bit_end  = (r_cnt == CNT_BIT_END);
  assign w_push_req = (r_state == ST_STOP) && w_bit_end && r_rxd_s;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_overrun  = w_push_req && w_full && !w_pop;

  assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_valid  = !w_empty;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Two-stage synchronizer for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
    end
  end

  // Frame decoder FSM with registered busy and error pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= w_overrun;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!r_rxd_s) begin
            r_state <= ST_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_START: begin
          if (r_cnt == CNT_HALF_END) begin
            r_cnt <= '0;
            if (!r_rxd_s) begin
              r_state <= ST_DATA;
              r_bit   <= 3'd0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_bit] <= r_rxd_s;
            r_bit          <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bit <= r_rxd_s;
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_rxd_s) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= (r_par_bit != even_parity(r_shift));
`endif
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Stay here until the line releases so a held-low line reports one error.
        ST_BREAK: begin
          r_cnt <= '0;
          if (r_rxd_s) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_BREAK;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule
